// File: rtl/stopwatch_core_p.sv
// Single-clock MM:SS stopwatch/timer core with count-up/down, preset, lap hold and expiry flag.
// The count and lap snapshot are kept as four BCD digits {min10, min1, sec10, sec1}.
module stopwatch_core_p #(
    parameter int unsigned MAX_MIN    = 59,
    parameter int unsigned PRESET_MIN = 5,
    parameter int unsigned PRESET_SEC = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_run,
    input  logic       tick_adj,
    input  logic       clr,
    input  logic       pause_tgl,
    input  logic       lap_tgl,
    input  logic       adj,
    input  logic       sel,
    input  logic       dir,
    output logic [3:0] min10,
    output logic [3:0] min1,
    output logic [3:0] sec10,
    output logic [3:0] sec1,
    output logic       running,
    output logic       lap_active,
    output logic       expired
);

    localparam logic [7:0]  MaxMinBcd = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};
    localparam logic [7:0]  MaxSecBcd = 8'h59;
    localparam logic [15:0] PresetBcd = {4'(PRESET_MIN / 10), 4'(PRESET_MIN % 10),
                                         4'(PRESET_SEC / 10), 4'(PRESET_SEC % 10)};

    logic [15:0] cnt_q, cnt_d;
    logic [15:0] snap_q, snap_d;
    logic        running_q, running_d;
    logic        lap_q, lap_d;
    logic        expired_q, expired_d;

    logic [7:0]  cnt_min, cnt_sec;
    logic        cnt_zero;

    // Two-digit BCD increment, wrapping to 00 after lim.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
        if (v == lim) begin
            return 8'h00;
        end
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Two-digit BCD decrement; callers never pass 00.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0) begin
            return {v[7:4] - 4'd1, 4'd9};
        end
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    assign cnt_min  = cnt_q[15:8];
    assign cnt_sec  = cnt_q[7:0];
    assign cnt_zero = (cnt_q == 16'h0000);

    always_comb begin
        cnt_d     = cnt_q;
        snap_d    = snap_q;
        running_d = running_q;
        lap_d     = lap_q;
        expired_d = expired_q;

        if (clr) begin
            cnt_d     = dir ? PresetBcd : 16'h0000;
            running_d = 1'b0;
            lap_d     = 1'b0;
            expired_d = 1'b0;
        end else begin
            if (pause_tgl) begin
                expired_d = 1'b0;
                // A finished count-down cannot be restarted from 00:00.
                running_d = ~running_q & ~(dir & cnt_zero);
            end

            if (lap_tgl) begin
                lap_d = ~lap_q;
                if (!lap_q) begin
                    snap_d = cnt_q;
                end
            end

            if (adj) begin
                if (tick_adj) begin
                    expired_d = 1'b0;
                    if (!sel) begin
                        cnt_d[15:8] = bcd_inc(cnt_min, MaxMinBcd);
                    end else begin
                        cnt_d[7:0] = bcd_inc(cnt_sec, MaxSecBcd);
                    end
                end
            end else if (running_q && tick_run) begin
                if (!dir) begin
                    cnt_d[7:0] = bcd_inc(cnt_sec, MaxSecBcd);
                    if (cnt_sec == MaxSecBcd) begin
                        cnt_d[15:8] = bcd_inc(cnt_min, MaxMinBcd);
                    end
                end else if (cnt_zero || cnt_q == 16'h0001) begin
                    // Reaching (or sitting at) 00:00 while counting down expires; overrides pause.
                    cnt_d     = 16'h0000;
                    running_d = 1'b0;
                    expired_d = 1'b1;
                end else if (cnt_sec == 8'h00) begin
                    cnt_d = {bcd_dec(cnt_min), MaxSecBcd};
                end else begin
                    cnt_d[7:0] = bcd_dec(cnt_sec);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= 16'h0000;
            snap_q    <= 16'h0000;
            running_q <= 1'b0;
            lap_q     <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            snap_q    <= snap_d;
            running_q <= running_d;
            lap_q     <= lap_d;
            expired_q <= expired_d;
        end
    end

    assign {min10, min1, sec10, sec1} = lap_q ? snap_q : cnt_q;
    assign running    = running_q;
    assign lap_active = lap_q;
    assign expired    = expired_q;

endmodule
